// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT
    } state_t;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_scan_ctrl_sevenseg.sv
// Combinational hex-to-seven-segment decoder, active-low gfe_dcba patterns.
module SevenSeg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] data,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (data)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Walks a packed hex value through one shared decoder, MSD first, with optional
// leading-zero blanking, then commits all digit patterns to the outputs at once.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_i,
    input  logic [NIB_W*NUM_DIGITS-1:0]   value_i,
    input  logic                          blank_lz_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic [SEG_W*NUM_DIGITS-1:0]   segs_o
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
    localparam int unsigned OUT_W = SEG_W * NUM_DIGITS;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   shadow_q, shadow_d;
    logic               blank_lz_q, blank_lz_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hi_zero_q, hi_zero_d;
    logic [OUT_W-1:0]   staging_q, staging_d;
    logic [OUT_W-1:0]   segs_q, segs_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [NIB_W-1:0]   nib_c;
    logic [SEG_W-1:0]   dec_c;
    logic               blank_c;

    assign nib_c   = shadow_q[NIB_W*32'(idx_q) +: NIB_W];
    assign blank_c = blank_lz_q && (nib_c == '0) && hi_zero_q && (idx_q != '0);

    SevenSeg u_dec (
        .data  (nib_c),
        .seg_c (dec_c)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        blank_lz_d = blank_lz_q;
        idx_d      = idx_q;
        hi_zero_d  = hi_zero_q;
        staging_d  = staging_q;
        segs_d     = segs_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    shadow_d   = value_i;
                    blank_lz_d = blank_lz_i;
                    idx_d      = IDX_W'(NUM_DIGITS - 1);
                    hi_zero_d  = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                staging_d[SEG_W*32'(idx_q) +: SEG_W] = blank_c ? SEG_BLANK : dec_c;
                hi_zero_d = hi_zero_q & (nib_c == '0);
                // Hold idx at 0 on the last digit so it never points past the shadow value.
                if (idx_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            COMMIT: begin
                segs_d  = staging_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            blank_lz_q <= 1'b0;
            idx_q      <= '0;
            hi_zero_q  <= 1'b1;
            staging_q  <= {NUM_DIGITS{SEG_BLANK}};
            segs_q     <= {NUM_DIGITS{SEG_BLANK}};
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            blank_lz_q <= blank_lz_d;
            idx_q      <= idx_d;
            hi_zero_q  <= hi_zero_d;
            staging_q  <= staging_d;
            segs_q     <= segs_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign segs_o  = segs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with NUM_DIGITS=4.
module tb_seg_scan_ctrl;

    localparam int unsigned ND = 4;

    logic          clk;
    logic          reset_n;
    logic          load_i;
    logic [15:0]   value_i;
    logic          blank_lz_i;
    logic          ready_o;
    logic          done_o;
    logic [27:0]   segs_o;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [15:0] value;
        logic        blank;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs[10];

    seg_scan_ctrl #(.NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load_i),
        .value_i    (value_i),
        .blank_lz_i (blank_lz_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .segs_o     (segs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one load in the current cycle, scrambles the inputs, and returns in the done cycle.
    task automatic do_update(input string name, input logic [15:0] v, input logic b,
                             input logic [27:0] exp);
        int  cyc;
        bit  rdy_leak;
        check({name, "_ready_before"}, 64'(ready_o), 64'(1));
        load_i     = 1'b1;
        value_i    = v;
        blank_lz_i = b;
        step();
        load_i     = 1'b0;
        value_i    = ~v;
        blank_lz_i = ~b;
        cyc        = 0;
        rdy_leak   = 1'b0;
        while (!done_o && cyc < 20) begin
            if (ready_o) rdy_leak = 1'b1;
            step();
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(ND + 1));
        check({name, "_ready_busy"}, 64'(rdy_leak), 64'(0));
        check({name, "_segs"}, 64'(segs_o), 64'(exp));
        check({name, "_ready_done"}, 64'(ready_o), 64'(1));
    endtask

    initial begin
        int ndone;
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        load_i     = 1'b0;
        value_i    = '0;
        blank_lz_i = 1'b0;

        vecs[0] = '{"v1A3F",   16'h1A3F, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E}};
        vecs[1] = '{"v00A0_b", 16'h00A0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[2] = '{"v00A0_n", 16'h00A0, 1'b0, {7'h40, 7'h40, 7'h08, 7'h40}};
        vecs[3] = '{"v0000_b", 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{"v0800_b", 16'h0800, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}};
        vecs[5] = '{"v0000_n", 16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{"v0123_b", 16'h0123, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30}};
        vecs[7] = '{"v4567",   16'h4567, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}};
        vecs[8] = '{"v9BDE",   16'h9BDE, 1'b1, {7'h10, 7'h03, 7'h21, 7'h06}};
        vecs[9] = '{"v000C_b", 16'h000C, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h46}};

        step();
        step();
        check("rst_segs",  64'(segs_o),  64'(28'hFFFFFFF));
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_done",  64'(done_o),  64'(0));
        reset_n = 1'b1;
        step();
        check("idle_segs_hold", 64'(segs_o), 64'(28'hFFFFFFF));

        foreach (vecs[i]) begin
            do_update(vecs[i].name, vecs[i].value, vecs[i].blank, vecs[i].segs);
            step();
            check({vecs[i].name, "_done_width"}, 64'(done_o), 64'(0));
            check({vecs[i].name, "_segs_hold"},  64'(segs_o), 64'(vecs[i].segs));
        end

        // Load during DECODE is ignored and yields a single done pulse.
        load_i     = 1'b1;
        value_i    = 16'h1A3F;
        blank_lz_i = 1'b0;
        step();
        load_i  = 1'b0;
        step();
        load_i  = 1'b1;
        value_i = 16'hFFFF;
        step();
        load_i  = 1'b0;
        ndone   = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_o) begin
                ndone++;
                check("busy_load_segs", 64'(segs_o), 64'({7'h79, 7'h08, 7'h30, 7'h0E}));
            end
            step();
        end
        check("busy_load_done_count", 64'(ndone), 64'(1));
        check("busy_load_segs_final", 64'(segs_o), 64'({7'h79, 7'h08, 7'h30, 7'h0E}));

        // Back-to-back: second load issued in the done cycle of the first.
        do_update("b2b_a", 16'h0123, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30});
        do_update("b2b_b", 16'h0800, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40});
        step();

        // Reset two cycles into DECODE discards the update and blanks the outputs.
        load_i     = 1'b1;
        value_i    = 16'h1234;
        blank_lz_i = 1'b0;
        step();
        load_i = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        check("midrst_segs",  64'(segs_o),  64'(28'hFFFFFFF));
        check("midrst_ready", 64'(ready_o), 64'(1));
        check("midrst_done",  64'(done_o),  64'(0));
        reset_n = 1'b1;
        ndone   = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done_o) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'(0));
        check("midrst_segs_after", 64'(segs_o), 64'(28'hFFFFFFF));

        do_update("post_rst", 16'h1A3F, 1'b0, {7'h79, 7'h08, 7'h30, 7'h0E});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
